// File: rtl/mem_copy_pkg.sv
// rtl/mem_copy_pkg.sv - shared types and default widths for the copy/fill engine
//
// Contents:
//   MCE_AW/MCE_DW/MCE_LW : default address, data and length widths
//   mce_state_t          : engine FSM states
//   mce_mode_t           : transfer mode (copy or fill)
package mem_copy_pkg;

  localparam int MCE_AW = 8;
  localparam int MCE_DW = 8;
  localparam int MCE_LW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } mce_state_t;

  typedef enum logic {
    MODE_COPY = 1'b0,
    MODE_FILL = 1'b1
  } mce_mode_t;

endpackage

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - block copy/fill engine arbitrating the data memory port
//
// Ports:
//   CLK, reset                 : clock, synchronous active-high reset
//   start, mode                : one-cycle request (IDLE only), 0=copy 1=fill
//   src_addr, dst_addr, length : transfer descriptor, length 0 is a no-op
//   fill_value                 : byte written in fill mode
//   cpu_*                      : CPU load/store request, passed through when idle
//   cpu_stall                  : high while the engine owns the memory port
//   done                       : one-cycle completion pulse
//   Data_*                     : single-port data memory interface
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int AW = MCE_AW,
  parameter int DW = MCE_DW,
  parameter int LW = MCE_LW
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [LW-1:0] length,
  input  logic [DW-1:0] fill_value,
  input  logic [AW-1:0] cpu_address,
  input  logic          cpu_read_en,
  input  logic          cpu_write_en,
  input  logic [DW-1:0] cpu_data_in,
  output logic          cpu_stall,
  output logic          done,
  output logic [AW-1:0] Data_address,
  output logic          Data_read_en,
  output logic          Data_write_en,
  output logic [DW-1:0] Data_memory_in,
  input  logic [DW-1:0] Data_memory_out
);

  mce_state_t    state_q, state_d;
  mce_mode_t     mode_q, mode_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] buf_q, buf_d;
  logic          cpu_stall_q;
  logic          done_q;

  // Next-state logic. In fill mode the byte buffer is loaded with fill_value
  // at start, so later changes on fill_value cannot leak into the transfer and
  // the WR datapath is the same for both modes.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d  = src_addr;
          dst_d  = dst_addr;
          cnt_d  = length;
          mode_d = mce_mode_t'(mode);
          if (mode_d == MODE_FILL) begin
            buf_d = fill_value;
          end
          if (length == '0) begin
            state_d = FIN;
          end else if (mode_d == MODE_FILL) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        buf_d   = Data_memory_out;
        state_d = WR;
      end
      WR: begin
        // Pointers wrap naturally at 2**AW.
        src_d = src_q + 1'b1;
        dst_d = dst_q + 1'b1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == LW'(1)) begin
          state_d = FIN;
        end else if (mode_q == MODE_FILL) begin
          state_d = WR;
        end else begin
          state_d = RD;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; stall and done are registered from the next state so
  // they line up with the state they describe.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= IDLE;
      mode_q      <= MODE_COPY;
      src_q       <= '0;
      dst_q       <= '0;
      cnt_q       <= '0;
      buf_q       <= '0;
      cpu_stall_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      cpu_stall_q <= (state_d == RD) || (state_d == WR);
      done_q      <= (state_d == FIN);
    end
  end

  assign cpu_stall = cpu_stall_q;
  assign done      = done_q;

  // Memory port mux. Writes are gated by reset in every state so an aborted
  // transfer (or a CPU store during reset) cannot touch memory.
  always_comb begin
    Data_address   = cpu_address;
    Data_read_en   = cpu_read_en;
    Data_write_en  = cpu_write_en & ~reset;
    Data_memory_in = cpu_data_in;
    case (state_q)
      RD: begin
        Data_address   = src_q;
        Data_read_en   = 1'b1;
        Data_write_en  = 1'b0;
        Data_memory_in = '0;
      end
      WR: begin
        Data_address   = dst_q;
        Data_read_en   = 1'b0;
        Data_write_en  = ~reset;
        Data_memory_in = buf_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - directed self-checking bench for mem_copy_engine
module tb_mem_copy_engine;

  logic       CLK;
  logic       reset;
  logic       start;
  logic       mode;
  logic [7:0] src_addr;
  logic [7:0] dst_addr;
  logic [7:0] length;
  logic [7:0] fill_value;
  logic [7:0] cpu_address;
  logic       cpu_read_en;
  logic       cpu_write_en;
  logic [7:0] cpu_data_in;
  logic       cpu_stall;
  logic       done;
  logic [7:0] Data_address;
  logic       Data_read_en;
  logic       Data_write_en;
  logic [7:0] Data_memory_in;
  logic [7:0] Data_memory_out;

  logic [7:0] mem [256];
  logic       mem_init;

  int checks;
  int errors;

  mem_copy_engine dut (
    .CLK             (CLK),
    .reset           (reset),
    .start           (start),
    .mode            (mode),
    .src_addr        (src_addr),
    .dst_addr        (dst_addr),
    .length          (length),
    .fill_value      (fill_value),
    .cpu_address     (cpu_address),
    .cpu_read_en     (cpu_read_en),
    .cpu_write_en    (cpu_write_en),
    .cpu_data_in     (cpu_data_in),
    .cpu_stall       (cpu_stall),
    .done            (done),
    .Data_address    (Data_address),
    .Data_read_en    (Data_read_en),
    .Data_write_en   (Data_write_en),
    .Data_memory_in  (Data_memory_in),
    .Data_memory_out (Data_memory_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: combinational read, write on posedge. Initial image is
  // M[i]=i except M[16]=254; it is not cleared by the engine reset.
  assign Data_memory_out = mem[Data_address];
  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
      mem[16] <= 8'd254;
    end else if (Data_write_en) begin
      mem[Data_address] <= Data_memory_in;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issues a start on the next negedge and runs until done (bounded).
  task automatic run_xfer(input logic m, input logic [7:0] s, input logic [7:0] d,
                          input logic [7:0] len, input logic [7:0] fv,
                          output int cyc, output int stalls, output int rds, output int wrs);
    bit seen;
    cyc = 0; stalls = 0; rds = 0; wrs = 0; seen = 0;
    @(negedge CLK);
    start = 1'b1; mode = m; src_addr = s; dst_addr = d; length = len; fill_value = fv;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge CLK);
      start = 1'b0;
      #1;
      cyc++;
      if (cpu_stall) stalls++;
      if (Data_read_en) rds++;
      if (Data_write_en) wrs++;
      if (done) seen = 1;
    end
    check("done_seen", int'(seen), 1);
    @(negedge CLK);
    #1;
    check("done_one_cycle", int'(done), 0);
  endtask

  int cyc, stalls, rds, wrs;
  bit done_seen;

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
    length = '0; fill_value = '0; cpu_address = 8'd5; cpu_read_en = 1'b0;
    cpu_write_en = 1'b1; cpu_data_in = 8'd99; mem_init = 1'b1;
    repeat (2) @(negedge CLK);
    mem_init = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check("rst_stall", int'(cpu_stall), 0);
    check("rst_done", int'(done), 0);
    check("rst_wr_gated", int'(Data_write_en), 0);
    check("rst_mem5", int'(mem[5]), 5);
    cpu_write_en = 1'b0;
    reset = 1'b0;

    // Copy len=1 16->32, also checking the per-cycle port behaviour.
    @(negedge CLK);
    start = 1'b1; mode = 1'b0; src_addr = 8'd16; dst_addr = 8'd32; length = 8'd1;
    #1;
    check("cp_start_stall", int'(cpu_stall), 0);
    @(negedge CLK);
    start = 1'b0; src_addr = 8'd0; dst_addr = 8'd0;
    #1;
    check("cp_rd_stall", int'(cpu_stall), 1);
    check("cp_rd_en", int'(Data_read_en), 1);
    check("cp_rd_addr", int'(Data_address), 16);
    @(negedge CLK);
    #1;
    check("cp_wr_stall", int'(cpu_stall), 1);
    check("cp_wr_en", int'(Data_write_en), 1);
    check("cp_wr_addr", int'(Data_address), 32);
    check("cp_wr_data", int'(Data_memory_in), 254);
    @(negedge CLK);
    #1;
    check("cp_fin_done", int'(done), 1);
    check("cp_fin_stall", int'(cpu_stall), 0);
    @(negedge CLK);
    #1;
    check("cp_done_drop", int'(done), 0);
    check("cp_m32", int'(mem[32]), 254);
    check("cp_m16", int'(mem[16]), 254);

    // Fill across the address wrap.
    run_xfer(1'b1, 8'd0, 8'd250, 8'd10, 8'hAA, cyc, stalls, rds, wrs);
    check("fill_latency", cyc, 11);
    check("fill_stalls", stalls, 10);
    check("fill_writes", wrs, 10);
    for (int i = 0; i < 10; i++) check("fill_byte", int'(mem[8'(250 + i)]), 8'hAA);
    check("fill_m4", int'(mem[4]), 4);
    check("fill_m249", int'(mem[249]), 249);

    // Overlapping forward copy propagates the first byte.
    run_xfer(1'b0, 8'd16, 8'd17, 8'd3, 8'h00, cyc, stalls, rds, wrs);
    check("ovl_latency", cyc, 7);
    check("ovl_m17", int'(mem[17]), 254);
    check("ovl_m18", int'(mem[18]), 254);
    check("ovl_m19", int'(mem[19]), 254);
    check("ovl_m20", int'(mem[20]), 20);

    // Zero-length copy.
    run_xfer(1'b0, 8'd60, 8'd70, 8'd0, 8'h00, cyc, stalls, rds, wrs);
    check("len0_latency", cyc, 1);
    check("len0_stalls", stalls, 0);
    check("len0_reads", rds, 0);
    check("len0_writes", wrs, 0);
    check("len0_m70", int'(mem[70]), 70);

    // CPU store while idle.
    @(negedge CLK);
    cpu_address = 8'd100; cpu_data_in = 8'd7; cpu_write_en = 1'b1;
    @(negedge CLK);
    cpu_write_en = 1'b0;
    check("cpu_store", int'(mem[100]), 7);

    // CPU store held during a fill: blocked while stalled, lands in FIN.
    @(negedge CLK);
    start = 1'b1; mode = 1'b1; dst_addr = 8'd60; length = 8'd3; fill_value = 8'h11;
    @(negedge CLK);
    start = 1'b0; fill_value = 8'h22;
    cpu_address = 8'd120; cpu_data_in = 8'd9; cpu_write_en = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 20 && !done_seen; i++) begin
      #1;
      if (done) done_seen = 1;
      else @(negedge CLK);
    end
    check("stall_done_seen", int'(done_seen), 1);
    check("stall_blocked", int'(mem[120]), 120);
    @(negedge CLK);
    cpu_write_en = 1'b0;
    check("stall_reissued", int'(mem[120]), 9);
    check("fill_latched_60", int'(mem[60]), 8'h11);
    check("fill_latched_62", int'(mem[62]), 8'h11);
    check("fill_end_63", int'(mem[63]), 63);

    // Reset in the middle of a len=5 fill at 40.
    @(negedge CLK);
    start = 1'b1; mode = 1'b1; dst_addr = 8'd40; length = 8'd5; fill_value = 8'hCC;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b1;
    #1;
    check("abort_wr_gated", int'(Data_write_en), 0);
    @(negedge CLK);
    reset = 1'b0;
    cpu_address = 8'd77; cpu_read_en = 1'b1;
    #1;
    check("abort_done", int'(done), 0);
    check("abort_stall", int'(cpu_stall), 0);
    check("abort_pass_addr", int'(Data_address), 77);
    check("abort_pass_rd", int'(Data_read_en), 1);
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      #1;
      if (done || cpu_stall) done_seen = 1;
    end
    cpu_read_en = 1'b0;
    check("abort_no_resume", int'(done_seen), 0);
    check("abort_m40", int'(mem[40]), 8'hCC);
    check("abort_m42", int'(mem[42]), 42);
    check("abort_m43", int'(mem[43]), 43);
    check("abort_m44", int'(mem[44]), 44);
    @(negedge CLK);
    cpu_address = 8'd200; cpu_data_in = 8'd55; cpu_write_en = 1'b1;
    @(negedge CLK);
    cpu_write_en = 1'b0;
    check("abort_store", int'(mem[200]), 55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
Block-copy/fill engine directly upstream of the data memory. It owns the memory's single address/read/write port and arbitrates it between the CPU datapath and an internal copy/fill FSM. When idle it is a transparent pass-through of CPU memory requests. When started, it copies or fills a contiguous byte range, one byte per memory transaction, and stalls the CPU until finished.

Parameters:
AW, 8, address width (memory depth 2**AW, pointers wrap modulo 2**AW)
DW, 8, data width
LW, 8, length field width (max transfer 2**LW-1 bytes)

Ports:
CLK  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high
start  in  1  one-cycle request; sampled only in IDLE
mode  in  1  0 = copy (src->dst), 1 = fill (fill_value->dst)
src_addr  in  AW  copy source start address
dst_addr  in  AW  destination start address
length  in  LW  byte count; 0 = no-op
fill_value  in  DW  byte written in fill mode
cpu_address  in  AW  CPU load/store address
cpu_read_en  in  1  CPU load
cpu_write_en  in  1  CPU store
cpu_data_in  in  DW  CPU store data
cpu_stall  out  1  high while the engine owns the port
done  out  1  one-cycle completion pulse
Data_address  out  AW  to data memory
Data_read_en  out  1  to data memory
Data_write_en  out  1  to data memory
Data_memory_in  out  DW  to data memory write data
Data_memory_out  in  DW  from data memory (combinational read data)

Behaviour:
- Reset: state=IDLE; pointers, count and byte buffer = 0; cpu_stall=0; done=0. Data_write_en is forced to 0 while reset is high.
- States: IDLE, RD, WR, FIN.
- IDLE:
  - Data_* outputs = cpu_* inputs, combinationally.
  - start=1: latch src_ptr, dst_ptr, cnt=length and mode.
  - length=0: go to FIN.
  - length!=0: go to RD for copy, or WR for fill.
  - The CPU request on the start cycle is still passed through.
- RD (copy only): Data_address=src_ptr, Data_read_en=1, Data_write_en=0. At posedge, buf<=Data_memory_out. Next state is WR.
- WR:
  - Data_address=dst_ptr, Data_write_en=1, Data_read_en=0.
  - Data_memory_in = buf (copy) or fill_value (fill).
  - At posedge: src_ptr++, dst_ptr++ (modulo 2**AW), cnt--.
  - cnt==1: go to FIN. Otherwise go to RD (copy) or stay in WR (fill).
- FIN: done=1 for exactly this cycle, cpu_stall=0, Data_* passed through from the CPU. Unconditionally go to IDLE; start in FIN is ignored.
- cpu_stall=1 in RD and WR only. CPU inputs are ignored while stalled; the CPU must hold its request.
- Latency from the start cycle to the done pulse:
  - copy: 2*length+1 cycles
  - fill: length+1 cycles
  - length=0: 1 cycle
- Address wrap: 255+1 -> 0 for both pointers.
- Overlap: forward byte-by-byte semantics. If dst is inside (src, src+len), source bytes already overwritten propagate; this is defined, not an error.
- start, mode, src_addr, dst_addr, length and fill_value are ignored outside IDLE. Inputs changing mid-transfer have no effect.
- Reset mid-transfer: abort immediately with no further writes and no done pulse. Memory contents already written remain as the memory's own reset leaves them.
- Unused outputs in engine states: Data_memory_in=0 in RD; Data_memory_in is a don't-care only in IDLE passthrough.

Decomposition:
- Package mem_copy_pkg:
  - typedef enum logic [1:0] {IDLE, RD, WR, FIN} mce_state_t
  - typedef enum logic {MODE_COPY, MODE_FILL} mce_mode_t
  - AW/DW/LW default localparams
- Single module. The port mux is an always_comb in the same file; no sub-module is warranted.

Test Plan:
- After memory reset (M[16]=254), copy src=16 dst=32 len=1 -> cpu_stall high 2 cycles, done pulses on cycle 3, M[32]=254, M[16] unchanged.
- Fill dst=250 len=10 value=0xAA -> 10 stall cycles; M[250..255] and M[0..3]=0xAA; M[4] and M[249] unchanged; done after 11 cycles.
- Overlapping copy src=16 dst=17 len=3 -> M[17], M[18], M[19] all =254 (forward propagation).
- len=0 copy -> no Data_write_en/Data_read_en from the engine, cpu_stall never asserts, done pulses the next cycle.
- Reset asserted in cycle 3 of a len=5 fill at dst=40 -> M[40] written; no write at dst=42 or beyond; no done; state IDLE; passthrough resumes.
- CPU store addr=100 data=7 in IDLE -> M[100]=7. Store issued while stalled -> not written; re-issued after done -> written.
